egg_timer_seq: RTL and testbench

Sequencing controller for the egg timer: owns the MM:SS countdown value, the one-second tick divider and the run/pause/alarm state machine. It takes single-cycle button pulses, produces the BCD digits for the display driver and an alarm flag for the buzzer. It sits between the button conditioning logic and the seven-segment/buzzer outputs.

---
 rtl/egg_timer_pkg.sv | 54 +++++
 rtl/egg_tick_gen.sv | 43 ++++
 rtl/egg_timer_seq.sv | 152 +++++++++++++++
 tb/tb_egg_timer_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/egg_timer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | egg_timer_pkg                                                     |
// | State encoding, BCD limits and BCD digit helpers for egg timer.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package egg_timer_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [7:0] BCD_SEC_MAX = 8'h59;
    localparam logic [7:0] BCD_MIN_MAX = 8'h99;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    // Two-digit BCD increment that wraps to 00 after max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [BCD_DIGIT_W-1:0] lo;
        logic [BCD_DIGIT_W-1:0] hi;
        lo = v[BCD_DIGIT_W-1:0];
        hi = v[2*BCD_DIGIT_W-1:BCD_DIGIT_W];
        if (v == max) begin
            lo = '0;
            hi = '0;
        end else if (lo == 4'd9) begin
            lo = '0;
            hi = hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

    // Two-digit BCD decrement; callers never pass 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [BCD_DIGIT_W-1:0] lo;
        logic [BCD_DIGIT_W-1:0] hi;
        lo = v[BCD_DIGIT_W-1:0];
        hi = v[2*BCD_DIGIT_W-1:BCD_DIGIT_W];
        if (lo == 4'd0) begin
            lo = 4'd9;
            hi = hi - 4'd1;
        end else begin
            lo = lo - 4'd1;
        end
        return {hi, lo};
    endfunction

endpackage
`default_nettype wire

// File: rtl/egg_tick_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | egg_tick_gen                                                      |
// | Freezable divider producing a registered one-cycle tick pulse.    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module egg_tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (en) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/egg_timer_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | egg_timer_seq                                                     |
// | MM:SS countdown, tick divider and run/pause/alarm sequencing.     |
// | Option: EGG_TIMER_AUTO_SILENCE_EN ends ALARM after ALARM_SECS.    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module egg_timer_seq
    import egg_timer_pkg::*;
#(
    parameter int TICK_DIV   = 1_000_000,
    parameter int ALARM_SECS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_min,
    input  logic       btn_sec,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       alarm,
    output logic       tick
);

    state_t     r_state;
    logic [7:0] r_min;
    logic [7:0] r_sec;
    logic       r_running;
    logic       r_alarm;

    logic       w_tick;
    logic       w_div_en;
    logic       w_div_clr;
    logic       w_time_zero;
    logic       w_last_sec;

`ifdef EGG_TIMER_AUTO_SILENCE_EN
    localparam int                ASEC_W    = $clog2(ALARM_SECS + 1);
    localparam logic [ASEC_W-1:0] ASEC_LAST = ASEC_W'(ALARM_SECS - 1);
    logic [ASEC_W-1:0] r_asec;

    // The divider keeps timing alarm seconds, but tick is only shown in RUN.
    assign w_div_en = ((r_state == ST_RUN) || (r_state == ST_ALARM)) && !btn_start;
    assign tick     = w_tick && (r_state == ST_RUN);
`else
    assign w_div_en = (r_state == ST_RUN) && !btn_start;
    assign tick     = w_tick;
`endif

    // Holding the divider clear in IDLE guarantees every fresh start begins at 0.
    assign w_div_clr   = btn_clear || (r_state == ST_IDLE);
    assign w_time_zero = (r_min == 8'h00) && (r_sec == 8'h00);
    assign w_last_sec  = (r_min == 8'h00) && (r_sec == 8'h01);

    egg_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (w_div_en),
        .clr  (w_div_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst || btn_clear) begin
            r_state   <= ST_IDLE;
            r_min     <= 8'h00;
            r_sec     <= 8'h00;
            r_running <= 1'b0;
            r_alarm   <= 1'b0;
`ifdef EGG_TIMER_AUTO_SILENCE_EN
            r_asec    <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (btn_start) begin
                        if (!w_time_zero) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end else if (btn_min) begin
                        r_min <= bcd_inc(r_min, BCD_MIN_MAX);
                    end else if (btn_sec) begin
                        r_sec <= bcd_inc(r_sec, BCD_SEC_MAX);
                    end
                end
                ST_RUN: begin
                    if (btn_start) begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                    end else if (w_tick) begin
                        if (r_sec == 8'h00) begin
                            r_sec <= BCD_SEC_MAX;
                            r_min <= bcd_dec(r_min);
                        end else begin
                            r_sec <= bcd_dec(r_sec);
                        end
                        if (w_last_sec) begin
                            r_state   <= ST_ALARM;
                            r_running <= 1'b0;
                            r_alarm   <= 1'b1;
`ifdef EGG_TIMER_AUTO_SILENCE_EN
                            r_asec    <= '0;
`endif
                        end
                    end
                end
                ST_PAUSE: begin
                    if (btn_start) begin
                        if (w_time_zero) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end else if (btn_min) begin
                        r_min <= bcd_inc(r_min, BCD_MIN_MAX);
                    end else if (btn_sec) begin
                        r_sec <= bcd_inc(r_sec, BCD_SEC_MAX);
                    end
                end
                ST_ALARM: begin
                    if (btn_start) begin
                        r_state <= ST_IDLE;
                        r_alarm <= 1'b0;
                    end
`ifdef EGG_TIMER_AUTO_SILENCE_EN
                    else if (w_tick) begin
                        if (r_asec == ASEC_LAST) begin
                            r_state <= ST_IDLE;
                            r_alarm <= 1'b0;
                        end else begin
                            r_asec <= r_asec + ASEC_W'(1);
                        end
                    end
`endif
                end
            endcase
        end
    end

    assign min_bcd = r_min;
    assign sec_bcd = r_sec;
    assign running = r_running;
    assign alarm   = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_egg_timer_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_egg_timer_seq                                                  |
// | Scoreboard bench: reference model queues expected outputs.        |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_egg_timer_seq;

    localparam int TDIV  = 4;
    localparam int ASECS = 2;
`ifdef EGG_TIMER_AUTO_SILENCE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_ALARM = 3;

    typedef struct packed {
        logic [7:0] mn;
        logic [7:0] sc;
        logic       run;
        logic       alm;
        logic       tk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start;
    logic       btn_clear;
    logic       btn_min;
    logic       btn_sec;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       alarm;
    logic       tick;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    // Reference model: time as plain minutes/seconds integers.
    int   m_mode, m_min, m_sec, m_div, m_asec;
    bit   m_tick;

    egg_timer_seq #(
        .TICK_DIV   (TDIV),
        .ALARM_SECS (ASECS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .btn_min   (btn_min),
        .btn_sec   (btn_sec),
        .min_bcd   (min_bcd),
        .sec_bcd   (sec_bcd),
        .running   (running),
        .alarm     (alarm),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic cycle(input bit r, input bit c, input bit st, input bit bm, input bit bs);
        exp_t e;
        bit   counting;
        bit   old_tick;
        int   total;
        rst       = r;
        btn_clear = c;
        btn_start = st;
        btn_min   = bm;
        btn_sec   = bs;
        if (r) begin
            m_mode = M_IDLE; m_min = 0; m_sec = 0; m_div = 0; m_tick = 0; m_asec = 0;
        end else begin
            counting = !c && !st && (m_mode == M_RUN || (AUTO && m_mode == M_ALARM));
            old_tick = m_tick;
            total    = m_min * 60 + m_sec;
            if (c) begin
                m_div = 0; m_tick = 0;
            end else if (counting) begin
                if (m_div == TDIV - 1) begin m_div = 0; m_tick = 1; end
                else begin m_div = m_div + 1; m_tick = 0; end
            end else begin
                m_tick = 0;
            end
            if (c) begin
                m_mode = M_IDLE; m_min = 0; m_sec = 0;
            end else begin
                case (m_mode)
                    M_IDLE: begin
                        if (st) begin
                            if (total > 0) begin m_mode = M_RUN; m_div = 0; end
                        end else if (bm) m_min = (m_min + 1) % 100;
                        else if (bs) m_sec = (m_sec + 1) % 60;
                    end
                    M_RUN: begin
                        if (st) m_mode = M_PAUSE;
                        else if (old_tick) begin
                            total = total - 1;
                            m_min = total / 60;
                            m_sec = total % 60;
                            if (total == 0) begin m_mode = M_ALARM; m_asec = 0; end
                        end
                    end
                    M_PAUSE: begin
                        if (st) m_mode = (total > 0) ? M_RUN : M_IDLE;
                        else if (bm) m_min = (m_min + 1) % 100;
                        else if (bs) m_sec = (m_sec + 1) % 60;
                    end
                    default: begin
                        if (st) m_mode = M_IDLE;
                        else if (AUTO && old_tick) begin
                            m_asec = m_asec + 1;
                            if (m_asec == ASECS) m_mode = M_IDLE;
                        end
                    end
                endcase
            end
        end
        e.mn  = to_bcd(m_min);
        e.sc  = to_bcd(m_sec);
        e.run = (m_mode == M_RUN);
        e.alm = (m_mode == M_ALARM);
        e.tk  = m_tick && (m_mode == M_RUN);
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    // 0 start, 1 clear, 2 minute, 3 second
    task automatic press(input int which);
        cycle(0, which == 1, which == 0, which == 2, which == 3);
    endtask

    task automatic press_n(input int which, input int n);
        for (int i = 0; i < n; i++) press(which);
    endtask

    task automatic random_phase(input int ncyc, input int p_min);
        for (int i = 0; i < ncyc; i++)
            cycle($urandom_range(0, 999) < 2, $urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 5,  $urandom_range(0, 99) < p_min,
                  $urandom_range(0, 99) < 12);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc = cyc + 1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks = n_checks + 1;
            if ({min_bcd, sec_bcd, running, alarm, tick} !== {e.mn, e.sc, e.run, e.alm, e.tk}) begin
                n_errors = n_errors + 1;
                $display("FAIL outputs cycle %0d: got %h:%h run=%b alarm=%b tick=%b, expected %h:%h run=%b alarm=%b tick=%b",
                         cyc, min_bcd, sec_bcd, running, alarm, tick, e.mn, e.sc, e.run, e.alm, e.tk);
            end
        end
    end

    initial begin
        // Reset defaults, then start at 00:00 is ignored.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        idle(2);
        press(0);
        idle(3);
        // 01:03 countdown to alarm, then alarm persistence / auto-silence.
        press_n(3, 3);
        press(2);
        press(0);
        idle(260);
        idle(100);
        press(0);
        idle(2);
        // Wraps and minute borrow from 10:00.
        press_n(3, 60);
        press_n(2, 100);
        press_n(2, 10);
        press(0);
        idle(8);
        press(1);
        // Pause at divider 2, hold, resume.
        press_n(2, 2);
        press(0);
        idle(2);
        press(0);
        idle(20);
        press(0);
        idle(6);
        press(1);
        // Pause coincident with a tick.
        press(2);
        press(0);
        idle(4);
        press(0);
        idle(5);
        press(1);
        // Clear beats start during RUN; clear from ALARM.
        press(2);
        press(0);
        idle(3);
        cycle(0, 1, 1, 0, 0);
        press(3);
        press(0);
        idle(10);
        press(1);
        idle(2);
        // Adjust to 00:00 while paused, then start returns to IDLE.
        press(3);
        press(0);
        press(0);
        press_n(3, 59);
        press(0);
        idle(3);
        // Reset while a tick is pending.
        press_n(3, 2);
        press(0);
        idle(4);
        cycle(1, 0, 0, 0, 0);
        idle(3);
        // Randomised episodes, some without minute presses so alarms occur.
        for (int ep = 0; ep < 20; ep++) begin
            random_phase(200, (ep % 2 == 0) ? 0 : 3);
        end
        idle(2);
        if (sb_q.size() != 0) begin
            n_errors = n_errors + 1;
            $display("FAIL scoreboard drain: got %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
